stream_mux_n: RTL

//  Registered N-to-1 multiplexer with a valid/ready handshake on every channel;

---
 rtl/stream_mux_n_pkg.sv | 14 +
 rtl/stream_mux_n_rr_arbiter.sv | 37 +++
 rtl/stream_mux_n.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stream_mux_n_pkg.sv
// Shared definitions for the stream_mux_n slice: select-mode encodings and
// default sizing used by the top and the round-robin arbiter.
package stream_mux_n_pkg;

    // Select mode encodings seen on the Mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Default sizing
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_SEL_W  = 2;

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel after the
// channel that was served last, wrapping modulo NUM_CH. Purely combinational;
// the Last pointer register lives in the top.
module stream_mux_n_rr_arbiter
    import stream_mux_n_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  last_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic              vld_o
);

    logic [SEL_W-1:0] cand;
    logic             found;

    // Rotating priority search starting one past the last served channel
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = SEL_W'((int'(last_i) + i) % NUM_CH);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/stream_mux_n.sv
// Registered NUM_CH-to-1 stream multiplexer with valid/ready on every channel.
// Fixed mode forwards the channel named by Sel; round-robin mode rotates over
// the valid channels. One output register gives 1-cycle latency and full
// throughput when the consumer drains and a new word is granted together.
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Mode,
    input  logic [SEL_W-1:0]        Sel,
    input  logic [NUM_CH*WIDTH-1:0] InData,
    input  logic [NUM_CH-1:0]       InValid,
    output logic [NUM_CH-1:0]       InReady,
    output logic [WIDTH-1:0]        OutData,
    output logic [SEL_W-1:0]        OutCh,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    SelErr
);

    // NUM_CH widened by one bit so Sel can be range-checked without overflow
    localparam logic [SEL_W:0]   NUM_CH_L = (SEL_W+1)'(NUM_CH);
    // Pointer reset value: last = NUM_CH-1 gives channel 0 first priority
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q,   out_ch_d;
    logic              out_vld_q,  out_vld_d;
    logic              sel_err_q,  sel_err_d;
    logic [SEL_W-1:0]  last_q,     last_d;

    logic              load;
    logic              sel_ok;
    logic              fix_vld;
    logic [NUM_CH-1:0] fix_onehot;
    logic [NUM_CH-1:0] rr_gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_vld;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_idx;
    logic [WIDTH-1:0]  data_sel;

    stream_mux_n_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req_i  (InValid),
        .last_i (last_q),
        .gnt_o  (rr_gnt),
        .idx_o  (rr_idx),
        .vld_o  (rr_vld)
    );

    // Resolve the grant for the current mode and the handshake towards producers
    always_comb begin
        sel_ok     = ({1'b0, Sel} < NUM_CH_L);
        fix_vld    = 1'b0;
        fix_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((Sel == SEL_W'(k)) && InValid[k]) begin
                fix_vld       = 1'b1;
                fix_onehot[k] = 1'b1;
            end
        end

        if (Mode == MODE_RR) begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end else begin
            gnt_vld = fix_vld;
            gnt_idx = Sel;
        end

        // Output register can take a word when empty or being drained this cycle
        load = !out_vld_q || OutReady;

        if (load && gnt_vld) begin
            InReady = (Mode == MODE_RR) ? rr_gnt : fix_onehot;
        end else begin
            InReady = '0;
        end

        data_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                data_sel = InData[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output register, round-robin pointer and error flag
    always_comb begin
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_vld_d  = out_vld_q;
        last_d     = last_q;
        sel_err_d  = sel_err_q || ((Mode == MODE_FIXED) && !sel_ok);

        if (load) begin
            out_vld_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = data_sel;
                out_ch_d   = gnt_idx;
                if (Mode == MODE_RR) begin
                    last_d = gnt_idx;
                end
            end
        end
    end

    // State registers; reset discards any held word immediately
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_vld_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            last_q     <= LAST_RST;
        end else begin
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_vld_q  <= out_vld_d;
            sel_err_q  <= sel_err_d;
            last_q     <= last_d;
        end
    end

    assign OutData  = out_data_q;
    assign OutCh    = out_ch_q;
    assign OutValid = out_vld_q;
    assign SelErr   = sel_err_q;

endmodule
